// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester round-robin arbiter and access sequencer in front
//            of a single-port, word-addressed data memory. Sub-word stores are
//            turned into read-modify-write sequences.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the memory (word index = addr[31:2])
// Ports
//   i_clk         clock, rising edge
//   i_reset_n     asynchronous active-low reset
//   i_req_vld     [2]     per-requester request valid (0 = core, 1 = debug/DMA)
//   i_req_addr    [2][32] byte address, bits [1:0] ignored
//   i_req_we      [2]     1 = write, 0 = read
//   i_req_wdata   [2][32] lane-aligned write data
//   i_req_bmask   [2][4]  write byte enables
//   o_req_rdy     [2]     grant, accept when vld & rdy
//   o_rsp_vld     [2]     one-cycle response pulse to the owner
//   o_rsp_rdata   [32]    read data (0 for writes and errors)
//   o_rsp_err             address out of range, valid with o_rsp_vld
//   o_mem_addr    [32]    word-aligned memory byte address
//   o_mem_wdata   [32]    memory write data
//   o_mem_wren            memory write enable
//   i_mem_rdata   [32]    memory combinational read data
// ============================================================================
module dmem_arbiter #(
    parameter int DEPTH_WORDS = 2048
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [1:0]      i_req_vld,
    input  logic [1:0][31:0] i_req_addr,
    input  logic [1:0]      i_req_we,
    input  logic [1:0][31:0] i_req_wdata,
    input  logic [1:0][3:0] i_req_bmask,
    output logic [1:0]      o_req_rdy,
    output logic [1:0]      o_rsp_vld,
    output logic [31:0]     o_rsp_rdata,
    output logic            o_rsp_err,
    output logic [31:0]     o_mem_addr,
    output logic [31:0]     o_mem_wdata,
    output logic            o_mem_wren,
    input  logic [31:0]     i_mem_rdata
);

    localparam logic [29:0] C_DEPTH = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_MERGE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_rr_ptr;
    logic        r_owner;
    logic        r_we;
    logic        r_err;
    logic [29:0] r_idx;
    logic [31:0] r_wdata;
    logic [3:0]  r_bmask;
    // Read data for reads, old word for partial writes.
    logic [31:0] r_data;

    logic        w_win;
    logic        w_accept;
    logic [29:0] w_sel_idx;
    logic        w_full;
    logic        w_partial;
    logic [31:0] w_merged;
    logic        w_unused_lsbs;

    // Byte offsets are not used by a word-addressed memory.
    assign w_unused_lsbs = ^{i_req_addr[0][1:0], i_req_addr[1][1:0]};

    // Winner: a lone requester always wins; on contention the pointer decides.
    always_comb begin
        w_win = 1'b0;
        case (i_req_vld)
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = r_rr_ptr;
            default: w_win = 1'b0;
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && (i_req_vld != 2'b00);
    assign w_sel_idx = i_req_addr[w_win][31:2];

    assign w_full    = r_we && !r_err && (r_bmask == 4'hF);
    assign w_partial = r_we && !r_err && (r_bmask != 4'h0) && (r_bmask != 4'hF);

    for (genvar b = 0; b < 4; b++) begin : g_merge
        assign w_merged[8*b +: 8] = r_bmask[b] ? r_wdata[8*b +: 8] : r_data[8*b +: 8];
    end

    // Next state and state-decoded outputs. Write enable is purely a state
    // decode so an asynchronous reset removes it immediately.
    always_comb begin
        w_state_nxt = r_state;
        o_req_rdy   = 2'b00;
        o_rsp_vld   = 2'b00;
        o_rsp_rdata = 32'h0;
        o_rsp_err   = 1'b0;
        o_mem_addr  = {r_idx, 2'b00};
        o_mem_wdata = r_wdata;
        o_mem_wren  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    o_req_rdy   = w_win ? 2'b10 : 2'b01;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                o_mem_wren  = w_full;
                w_state_nxt = w_partial ? S_MERGE : S_RESP;
            end
            S_MERGE: begin
                o_mem_wren  = 1'b1;
                o_mem_wdata = w_merged;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                o_rsp_vld   = r_owner ? 2'b10 : 2'b01;
                o_rsp_rdata = r_we ? 32'h0 : r_data;
                o_rsp_err   = r_err;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_idx    <= 30'h0;
            r_wdata  <= 32'h0;
            r_bmask  <= 4'h0;
            r_data   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_win;
                        r_idx   <= w_sel_idx;
                        r_we    <= i_req_we[w_win];
                        r_wdata <= i_req_wdata[w_win];
                        r_bmask <= i_req_bmask[w_win];
                        r_err   <= (w_sel_idx >= C_DEPTH);
                    end
                end
                S_ACCESS: r_data <= r_err ? 32'h0 : i_mem_rdata;
                // Pointer moves only after a completed transaction, so a lone
                // requester keeps priority over itself.
                S_RESP:   r_rr_ptr <= ~r_owner;
                default:  ;
            endcase
        end
    end

endmodule
`default_nettype wire
